// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: ctrl op encodings, FSM state
// encodings and the stage-index width.
package shift_sequencer_pkg;

  // Stage index k counts 4..0, so three bits are enough.
  localparam int unsigned K_W = 3;

  localparam logic [1:0] CTRL_SLL = 2'b00;
  localparam logic [1:0] CTRL_SRL = 2'b01;
  localparam logic [1:0] CTRL_SRA = 2'b10;  // 2'b11 also decodes as SRA

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Any op with bit 1 set is an arithmetic right shift.
  function automatic logic is_sra(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Fixed-amount combinational shifter used as one stage of the sequencer.
// Ports:
//   en     - apply the shift; when low, din passes through unchanged
//   op     - ctrl encoding (SLL / SRL / SRA)
//   din    - operand
//   dout_c - combinational result
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SHIFT_AMOUNT = 1
) (
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  // Select the shifted operand per op, or pass through when disabled.
  always_comb begin
    dout_c = din;
    if (en) begin
      if (is_sra(op)) begin
        dout_c = WIDTH'($signed(din) >>> SHIFT_AMOUNT);
      end else if (op == CTRL_SRL) begin
        dout_c = din >> SHIFT_AMOUNT;
      end else begin
        dout_c = din << SHIFT_AMOUNT;
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: applies 2^k stages (k = 4..0) over five RUN
// cycles, then presents the result with a valid/ready handshake.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - request an operation (accepted only in IDLE)
//   A, B, ctrl        - shift amount (A[4:0]), operand, op select
//   busy              - operation running or result held
//   dout_valid, dout  - completed result
//   dout_ready        - consumer accepts the result
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic             busy,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   amt_q, amt_d;
  logic [1:0]           op_q, op_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     stage_out [SHAMT_W];
  logic [WIDTH-1:0]     run_res;

  // Only the low shift-amount bits of A are meaningful.
  logic unused_a;
  assign unused_a = ^A[WIDTH-1:SHAMT_W];

  // One fixed shifter per stage; only the stage matching k may shift.
  for (genvar gi = 0; gi < int'(SHAMT_W); gi++) begin : g_stage
    shift_sequencer_shifter #(
      .WIDTH        (WIDTH),
      .SHIFT_AMOUNT (1 << gi)
    ) u_shifter (
      .en     (amt_q[gi] && (k_q == K_W'(gi))),
      .op     (op_q),
      .din    (acc_q),
      .dout_c (stage_out[gi])
    );
  end

  // Stage output mux by k.
  always_comb begin
    run_res = acc_q;
    for (int i = 0; i < int'(SHAMT_W); i++) begin
      if (k_q == K_W'(i)) run_res = stage_out[i];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    amt_d        = amt_q;
    op_d         = op_q;
    k_d          = k_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    case (state_q)
      ST_IDLE: begin
        dout_valid_d = 1'b0;
        if (start) begin
          acc_d   = B;
          amt_d   = A[SHAMT_W-1:0];
          op_d    = ctrl;
          k_d     = K_W'(SHAMT_W - 1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = run_res;
        if (k_q == '0) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      ST_DONE: begin
        dout_d       = acc_q;
        dout_valid_d = 1'b1;
        // Release only once the consumer has seen a valid result.
        if (dout_valid_q && dout_ready) begin
          state_d      = ST_IDLE;
          dout_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        dout_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      amt_q        <= '0;
      op_q         <= '0;
      k_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      amt_q        <= amt_d;
      op_q         <= op_d;
      k_q          <= k_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  ctrl;
  logic        busy;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout;

  int tests = 0;
  int fails = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (a),
    .B          (b),
    .ctrl       (ctrl),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] bv, input logic [31:0] av,
                                           input logic [1:0] cv);
    logic [4:0] sh;
    sh = av[4:0];
    case (cv)
      2'b00:   return bv << sh;
      2'b01:   return bv >> sh;
      default: return 32'($signed(bv) >>> sh);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op at IDLE and let the accepting edge pass.
  task automatic launch(input logic [31:0] bv, input logic [31:0] av, input logic [1:0] cv);
    b = bv; a = av; ctrl = cv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges from acceptance until dout_valid, bounded.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!dout_valid && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic handshake(input string tag);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check({tag, "_valid_fall"}, 32'(dout_valid), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [31:0] bv, input logic [31:0] av,
                           input logic [1:0] cv, input logic [31:0] exp);
    int edges;
    launch(bv, av, cv);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(edges);
    check({tag, "_latency"}, 32'(edges), 32'd6);
    check({tag, "_dout"}, dout, exp);
    handshake(tag);
  endtask

  initial begin
    int edges;
    logic [31:0] rb, ra, exp_r;
    logic [1:0]  rc;
    logic        saw_valid;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = '0; dout_ready = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", dout, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // SLL full amount, with latency and busy.
    launch(32'h0000_0001, 32'd31, 2'b00);
    check("sll31_busy", 32'(busy), 32'd1);
    check("sll31_valid_low", 32'(dout_valid), 32'd0);
    wait_valid(edges);
    check("sll31_latency", 32'(edges), 32'd6);
    check("sll31_dout", dout, 32'h8000_0000);
    check("sll31_busy_done", 32'(busy), 32'd1);
    handshake("sll31");

    // Right shifts of a negative operand.
    run_check("sra10", 32'h8000_0000, 32'd4, 2'b10, 32'hF800_0000);
    run_check("sra11", 32'h8000_0000, 32'd4, 2'b11, 32'hF800_0000);
    run_check("srl01", 32'h8000_0000, 32'd4, 2'b01, 32'h0800_0000);
    // Upper A bits must be ignored: 0xFFFFFFE3 -> amount 3.
    run_check("a_upper", 32'h0000_00F0, 32'hFFFF_FFE3, 2'b00, 32'h0000_0780);

    // Zero amount, with inputs scrambled and start pulsed during RUN.
    launch(32'hDEAD_BEEF, 32'd0, 2'b00);
    a = 32'd17; b = 32'h1234_5678; ctrl = 2'b10; start = 1'b1;
    tick();
    start = 1'b0; a = 32'd5; ctrl = 2'b01;
    wait_valid(edges);
    check("zero_latency", 32'(edges + 1), 32'd6);
    check("zero_dout", dout, 32'hDEAD_BEEF);
    handshake("zero");

    // Back-pressure: hold in DONE, pulse start, then release.
    launch(32'hF0F0_F0F0, 32'd4, 2'b00);
    wait_valid(edges);
    check("bp_latency", 32'(edges), 32'd6);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      b = 32'h0BAD_0000 + 32'(i); a = 32'(i); ctrl = 2'(i);
      tick();
      check("bp_dout_hold", dout, 32'h0F0F_0F00);
      check("bp_valid_hold", 32'(dout_valid), 32'd1);
      check("bp_busy_hold", 32'(busy), 32'd1);
    end
    start = 1'b0;
    handshake("bp");
    check("bp_dout_retained", dout, 32'h0F0F_0F00);
    // Back-to-back: accept in the IDLE cycle right after the handshake.
    run_check("b2b", 32'hAAAA_5555, 32'd1, 2'b01, 32'h5555_2AAA);
    check("idle_dout_retained", dout, 32'h5555_2AAA);

    // Asynchronous reset at RUN k=2.
    launch(32'hFFFF_0000, 32'd3, 2'b00);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_valid || busy) saw_valid = 1'b1;
    end
    check("rst_no_result", 32'(saw_valid), 32'd0);
    check("rst_dout_zero", dout, 32'd0);
    run_check("post_rst", 32'h0000_0003, 32'd2, 2'b00, 32'h0000_000C);

    // Random operations against the one-step reference.
    for (int n = 0; n < 2000; n++) begin
      rb = $urandom;
      ra = $urandom;
      rc = 2'($urandom_range(0, 3));
      exp_r = ref_shift(rb, ra, rc);
      launch(rb, ra, rc);
      wait_valid(edges);
      check("rand_dout", dout, exp_r);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
